// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//   Feeds a byte-level SPI write engine. Host bytes are queued in a small FIFO
//   together with a last flag. The sequencer groups them into frames under an
//   active-low chip select, enforces CS setup/hold/inter-frame gap timing, and
//   hands each byte to the engine through its go/done handshake.
//
// Build option:
//   SPI_FRAME_SEQ_INIT_EN - when defined, an 8-byte init table is played as
//   frames after every reset, before any host data is accepted.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   in_data/in_last   byte offered by the host and its end-of-frame flag
//   in_valid/in_ready host handshake; a push happens when both are high
//   spi_cs_n          chip select to the device (active low)
//   spi_go/spi_data   one-cycle start pulse and byte to the SPI engine
//   spi_done          engine idle flag (high when idle)
//   busy              sequencer active or FIFO holding data
//   frame_done        one-cycle pulse when spi_cs_n rises at frame end
module spi_frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int CS_SETUP   = 4,
  parameter int CS_HOLD    = 4,
  parameter int CS_GAP     = 8,
  parameter int CNT_BITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              spi_cs_n,
  output logic              spi_go,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_done,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  localparam logic [CNT_BITS-1:0] SETUP_END = CNT_BITS'(CS_SETUP - 1);
  localparam logic [CNT_BITS-1:0] HOLD_END  = CNT_BITS'(CS_HOLD - 1);
  localparam logic [CNT_BITS-1:0] GAP_END   = CNT_BITS'(CS_GAP - 1);
  localparam logic [FIFO_AW:0]    FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW:0]    fifo_cnt;
  logic [2:0]          state;
  logic [CNT_BITS-1:0] dly_cnt;
  logic                last_r;
  logic                push;
  logic                pop;
  logic                fifo_pop;
  logic                src_avail;
  logic                init_busy;
  logic [DATA_W:0]     head;

`ifdef SPI_FRAME_SEQ_INIT_EN
  localparam logic [3:0] INIT_LEN = 4'd8;

  logic [3:0] init_ptr;

  // {last, byte}; three frames: 1 byte, 2 bytes, 5 bytes.
  function automatic logic [DATA_W:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    init_entry = {1'b1, DATA_W'(8'h06)};
      3'd1:    init_entry = {1'b0, DATA_W'(8'h01)};
      3'd2:    init_entry = {1'b1, DATA_W'(8'h00)};
      3'd3:    init_entry = {1'b0, DATA_W'(8'h02)};
      3'd4:    init_entry = {1'b0, DATA_W'(8'h00)};
      3'd5:    init_entry = {1'b0, DATA_W'(8'h10)};
      3'd6:    init_entry = {1'b0, DATA_W'(8'hA5)};
      default: init_entry = {1'b1, DATA_W'(8'h5A)};
    endcase
  endfunction

  // The table stays the byte source until the GAP of its final frame ends,
  // so host traffic can never slip in between init frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_ptr  <= '0;
      init_busy <= 1'b1;
    end else begin
      if (pop && init_busy)
        init_ptr <= init_ptr + 4'd1;
      if (init_busy && state == S_GAP && dly_cnt == GAP_END && init_ptr == INIT_LEN)
        init_busy <= 1'b0;
    end
  end

  assign head      = init_busy ? init_entry(init_ptr[2:0]) : fifo_mem[rd_ptr];
  assign src_avail = init_busy ? (init_ptr != INIT_LEN) : (fifo_cnt != '0);
  assign fifo_pop  = pop && !init_busy;
`else
  assign init_busy = 1'b0;
  assign head      = fifo_mem[rd_ptr];
  assign src_avail = (fifo_cnt != '0);
  assign fifo_pop  = pop;
`endif

  assign in_ready = !init_busy && (fifo_cnt != FIFO_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_LOAD) && src_avail && spi_done;
  assign busy     = init_busy || (state != S_IDLE) || (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (fifo_pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      spi_cs_n   <= 1'b1;
      spi_go     <= 1'b0;
      spi_data   <= '0;
      frame_done <= 1'b0;
      dly_cnt    <= '0;
      last_r     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (src_avail) begin
            spi_cs_n <= 1'b0;
            dly_cnt  <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (dly_cnt == SETUP_END)
            state <= S_LOAD;
          else
            dly_cnt <= dly_cnt + CNT_BITS'(1);
        end
        // An empty source here is an underrun: CS stays low until data arrives.
        S_LOAD: begin
          if (pop) begin
            spi_data <= head[DATA_W-1:0];
            last_r   <= head[DATA_W];
            spi_go   <= 1'b1;
            state    <= S_SEND;
          end
        end
        // The engine only drops done the cycle after go, so done is stale here.
        S_SEND: begin
          spi_go <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done) begin
            if (last_r) begin
              dly_cnt <= '0;
              state   <= S_HOLD;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (dly_cnt == HOLD_END) begin
            spi_cs_n   <= 1'b1;
            frame_done <= 1'b1;
            dly_cnt    <= '0;
            state      <= S_GAP;
          end else begin
            dly_cnt <= dly_cnt + CNT_BITS'(1);
          end
        end
        S_GAP: begin
          if (dly_cnt == GAP_END)
            state <= S_IDLE;
          else
            dly_cnt <= dly_cnt + CNT_BITS'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb_spi_frame_sequencer
//   Randomized bench for spi_frame_sequencer. A behavioural engine model drives
//   spi_done; a queue of pushed {last, byte} entries is the reference for byte
//   order and frame grouping, and CS timing is measured against the setup,
//   hold and gap figures.
module tb_spi_frame_sequencer;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       spi_cs_n;
  logic       spi_go;
  logic [7:0] spi_data;
  logic       spi_done;
  logic       busy;
  logic       frame_done;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  bit         stall      = 1'b0;
  bit         init_guard = 1'b0;
  int         go_count   = 0;

  always #5 clk = ~clk;

  spi_frame_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .spi_cs_n   (spi_cs_n),
    .spi_go     (spi_go),
    .spi_data   (spi_data),
    .spi_done   (spi_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef SPI_FRAME_SEQ_INIT_EN
  function automatic logic [8:0] init_tab(input int i);
    case (i)
      0:       init_tab = 9'h106;
      1:       init_tab = 9'h001;
      2:       init_tab = 9'h100;
      3:       init_tab = 9'h002;
      4:       init_tab = 9'h000;
      5:       init_tab = 9'h010;
      6:       init_tab = 9'h0A5;
      default: init_tab = 9'h15A;
    endcase
  endfunction
`endif

  // Monitor and SPI engine model, evaluated 1 time unit after each clock edge.
  initial begin : mon
    bit         prev_cs = 1'b1;
    bit         prev_go = 1'b0;
    bit         gap_valid = 1'b0;
    bit         frame_closed = 1'b0;
    bit         first_go = 1'b0;
    bit         stalled_frame = 1'b0;
    bit         hold_run = 1'b0;
    bit         last_pending = 1'b0;
    bit         rise;
    int         k = 0;
    int         high_cnt = 0;
    int         hold_cnt = 0;
    int         eng_cnt = 0;
    logic [8:0] e;
    spi_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_cs = 1'b1; prev_go = 1'b0; gap_valid = 1'b0; frame_closed = 1'b0;
        first_go = 1'b0; hold_run = 1'b0; last_pending = 1'b0; eng_cnt = 0;
        spi_done = 1'b1;
        exp_q.delete();
`ifdef SPI_FRAME_SEQ_INIT_EN
        for (int i = 0; i < 8; i++) exp_q.push_back(init_tab(i));
        init_guard = 1'b1;
`endif
        continue;
      end
      if (init_guard && in_ready) begin
        chk("init_before_ready", 32'(exp_q.size()), 32'd0);
        init_guard = 1'b0;
      end
      if (prev_cs && !spi_cs_n) begin
        // CS high time covers GAP plus the IDLE cycle that re-arms a frame.
        if (gap_valid) chk("cs_gap", 32'(high_cnt >= CS_GAP + 1), 32'd1);
        k = 0;
        first_go = 1'b1;
        stalled_frame = stall;
      end else if (!spi_cs_n) begin
        k++;
      end
      if (stall && !spi_cs_n) stalled_frame = 1'b1;
      rise = !prev_cs && spi_cs_n;
      if (frame_done || rise) chk("frame_done", 32'(frame_done), 32'(rise));
      if (hold_run) hold_cnt++;
      if (rise) begin
        chk("frame_end_last", 32'(frame_closed), 32'd1);
        // One cycle for the sequencer to sample done, then CS_HOLD cycles.
        chk("cs_hold", hold_run ? 32'(hold_cnt) : 32'd0, 32'(CS_HOLD + 1));
        hold_run = 1'b0;
        frame_closed = 1'b0;
        gap_valid = 1'b1;
        high_cnt = 1;
      end else if (spi_cs_n) begin
        high_cnt++;
      end
      if (spi_go) begin
        go_count++;
        chk("go_pulse", 32'(prev_go), 32'd0);
        chk("cs_at_go", 32'(spi_cs_n), 32'd0);
        chk("done_at_go", 32'(spi_done), 32'd1);
        if (first_go && !stalled_frame) chk("cs_setup", 32'(k), 32'(CS_SETUP + 1));
        first_go = 1'b0;
        chk("go_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("data", 32'(spi_data), 32'(e[7:0]));
          chk("byte_after_last", 32'(frame_closed), 32'd0);
          frame_closed = e[8];
        end
      end
      prev_cs = spi_cs_n;
      prev_go = spi_go;
      // Engine: drops done after go, shifts for a random time, then idles.
      if (spi_go) begin
        spi_done = 1'b0;
        eng_cnt = $urandom_range(2, 6);
        last_pending = frame_closed;
      end else if (stall) begin
        spi_done = 1'b0;
      end else begin
        if (eng_cnt > 0) eng_cnt--;
        if (eng_cnt == 0 && !spi_done) begin
          spi_done = 1'b1;
          if (last_pending) begin
            hold_run = 1'b1;
            hold_cnt = 0;
            last_pending = 1'b0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int w;
    bit acc;
    w = 0;
    acc = 1'b0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    while (!acc && w < 3000) begin
      if (!init_guard) chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (in_ready) begin
        exp_q.push_back({l, d});
        acc = 1'b1;
      end
      step(1);
      w++;
    end
    in_valid = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 5000) begin
      step(1);
      w++;
    end
    chk("drain", 32'(w < 5000), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cs", 32'(spi_cs_n), 32'd1);
  endtask

  initial begin : main
    int target;
    int w;
    int go_mark;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_go", 32'(spi_go), 32'd0);
    chk("rst_data", 32'(spi_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef SPI_FRAME_SEQ_INIT_EN
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
`else
    chk("rst_busy", 32'(busy), 32'd0);
`endif
    #2 rst = 1'b0;
    step(1);
`ifndef SPI_FRAME_SEQ_INIT_EN
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_cs", 32'(spi_cs_n), 32'd1);
`endif

    // Single two-byte frame, then two one-byte frames back to back.
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
    drain();
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    drain();

    // FIFO full with the engine stalled.
    stall = 1'b1;
    step(2);
    for (int i = 0; i < DEPTH; i++) push(8'($urandom), 1'(i == DEPTH - 1));
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    in_data = 8'hEE;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("full_held", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    stall = 1'b0;
    push(8'hEE, 1'b1);
    drain();

    // Underrun mid-frame keeps CS low.
    push(8'h11, 1'b0);
    step(50);
    chk("underrun_cs", 32'(spi_cs_n), 32'd0);
    chk("underrun_busy", 32'(busy), 32'd1);
    push(8'h22, 1'b1);
    drain();

    // Random frames of 1..4 bytes with random host pauses.
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        push(8'($urandom), 1'(b == len - 1));
        if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
      end
    end
    drain();

    // Reset while waiting on the second byte of a four-byte frame.
    target = go_count + exp_q.size() + 2;
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    push(8'hC4, 1'b1);
    w = 0;
    while (go_count < target && w < 500) begin
      step(1);
      w++;
    end
    chk("second_go_seen", 32'(go_count >= target), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cs", 32'(spi_cs_n), 32'd1);
    chk("async_rst_go", 32'(spi_go), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    go_mark = go_count;
    step(1);
`ifdef SPI_FRAME_SEQ_INIT_EN
    chk("rel_busy", 32'(busy), 32'd1);
    drain();
    chk("rel_go_count", 32'(go_count - go_mark), 32'd8);
`else
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_ready", 32'(in_ready), 32'd1);
    step(30);
    chk("rel_no_go", 32'(go_count - go_mark), 32'd0);
`endif

    // A byte pushed after reset recovery goes out next.
    push(8'h5A, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
